// File: rtl/dfr_matrix_multiply_if.sv
// Memory-side bus of the DFR output-layer multiplier:
// X and W read ports plus the Y write port.
interface dfr_matrix_multiply_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] x_addr;
    logic [DATA_WIDTH-1:0] x_data;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [ADDR_WIDTH-1:0] y_addr;
    logic [DATA_WIDTH-1:0] y_data;
    logic                  y_wen;

    modport master (
        output x_addr,
        input  x_data,
        output w_addr,
        input  w_data,
        output y_addr,
        output y_data,
        output y_wen
    );

    modport slave (
        input  x_addr,
        output x_data,
        input  w_addr,
        output w_data,
        input  y_addr,
        input  y_data,
        input  y_wen
    );
endinterface

// File: rtl/dfr_matrix_multiply.sv
// DFR output layer: Y = X * W over external memories.
// Define DFR_MM_SATURATE_EN to saturate results instead of wrapping.
module dfr_matrix_multiply #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int X_ROWS        = 5,
    parameter int Y_COLS        = 5,
    parameter int X_COLS_Y_ROWS = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic start,
    output logic busy,
    output logic done,
    dfr_matrix_multiply_if.master mem
);
    localparam int K  = X_COLS_Y_ROWS;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + $clog2(K + 1);

    localparam logic [ADDR_WIDTH-1:0] K_W    = ADDR_WIDTH'(K);
    localparam logic [ADDR_WIDTH-1:0] YC_W   = ADDR_WIDTH'(Y_COLS);
    localparam logic [ADDR_WIDTH-1:0] K_LAST = ADDR_WIDTH'(K - 1);
    localparam logic [ADDR_WIDTH-1:0] I_LAST = ADDR_WIDTH'(X_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] J_LAST = ADDR_WIDTH'(Y_COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE
    } state_t;

    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] i, j, k;
    logic [ADDR_WIDTH-1:0] x_q, w_q;
    logic [ADDR_WIDTH-1:0] x_cur, w_cur;
    logic signed [AW-1:0]  acc;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  prod_ext;
    logic [DATA_WIDTH-1:0] result;
    logic                  pipe;
    logic                  last_elem;

    assign x_cur     = i * K_W + k;
    assign w_cur     = k * YC_W + j;
    assign last_elem = (i == I_LAST) && (j == J_LAST);

    assign prod     = $signed(mem.x_data) * $signed(mem.w_data);
    assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};

`ifdef DFR_MM_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX =
        {{(AW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN =
        {{(AW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    always_comb begin
        result = acc[DATA_WIDTH-1:0];
        if (acc > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    assign result = acc[DATA_WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Addresses are live in RUN and otherwise hold the last issued pair.
    always_comb begin
        state_n    = state;
        mem.x_addr = x_q;
        mem.w_addr = w_q;
        mem.y_wen  = 1'b0;
        mem.y_addr = '0;
        mem.y_data = '0;
        unique case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                mem.x_addr = x_cur;
                mem.w_addr = w_cur;
                if (k == K_LAST) state_n = DRAIN;
            end
            DRAIN: begin
                state_n = WRITE;
            end
            WRITE: begin
                mem.y_wen  = 1'b1;
                mem.y_addr = i * YC_W + j;
                mem.y_data = result;
                state_n    = last_elem ? IDLE : RUN;
            end
            default: state_n = IDLE;
        endcase
        if (clr) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i    <= '0;
            j    <= '0;
            k    <= '0;
            x_q  <= '0;
            w_q  <= '0;
            acc  <= '0;
            pipe <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (clr) begin
            i    <= '0;
            j    <= '0;
            k    <= '0;
            x_q  <= '0;
            w_q  <= '0;
            acc  <= '0;
            pipe <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            pipe <= (state == RUN);
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        i    <= '0;
                        j    <= '0;
                        k    <= '0;
                        acc  <= '0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    x_q <= x_cur;
                    w_q <= w_cur;
                    k   <= k + 1'b1;
                    if (pipe) acc <= acc + prod_ext;
                end
                DRAIN: begin
                    if (pipe) acc <= acc + prod_ext;
                end
                WRITE: begin
                    acc <= '0;
                    k   <= '0;
                    if (j == J_LAST) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                    if (last_elem) begin
                        i    <= '0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dfr_matrix_multiply.sv
// Directed bench: 5x5x5 32-bit instance and a 2x2x2 8-bit instance
// sharing one clock and reset.
module tb_dfr_matrix_multiply;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sa = 1'b0, ca = 1'b0, sb = 1'b0, cb = 1'b0;
    logic busya, donea, busyb, doneb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dfr_matrix_multiply_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    dfr_matrix_multiply_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8))  ifb ();

    dfr_matrix_multiply u_a (
        .clk(clk), .rst(rst), .clr(ca), .start(sa),
        .busy(busya), .done(donea), .mem(ifa.master)
    );

    dfr_matrix_multiply #(
        .ADDR_WIDTH(32), .DATA_WIDTH(8),
        .X_ROWS(2), .Y_COLS(2), .X_COLS_Y_ROWS(2)
    ) u_b (
        .clk(clk), .rst(rst), .clr(cb), .start(sb),
        .busy(busyb), .done(doneb), .mem(ifb.master)
    );

    logic [31:0] xa [25];
    logic [31:0] wa [25];
    logic [31:0] exp_a [25];
    logic [7:0]  xb [4];
    logic [7:0]  wb [4];
    int yb_cnt = 0;

    logic [31:0] ra [25];
    logic [31:0] rd [25];
    int          rc [25];
    logic [31:0] b_wa [8];
    logic [7:0]  b_wd [8];

    always @(posedge clk) begin
        ifa.x_data <= (ifa.x_addr < 25) ? xa[ifa.x_addr[4:0]] : '0;
        ifa.w_data <= (ifa.w_addr < 25) ? wa[ifa.w_addr[4:0]] : '0;
        ifb.x_data <= (ifb.x_addr < 4) ? xb[ifb.x_addr[1:0]] : '0;
        ifb.w_data <= (ifb.w_addr < 4) ? wb[ifb.w_addr[1:0]] : '0;
        if (ifb.y_wen) yb_cnt <= yb_cnt + 1;
    end

    function automatic logic [31:0] fin32(input longint s);
`ifdef DFR_MM_SATURATE_EN
        if (s > 64'sd2147483647) return 32'h7fffffff;
        if (s < -64'sd2147483648) return 32'h80000000;
`endif
        return 32'(s);
    endfunction

    task automatic run_b(input int extra_start, output int nw,
                         output int done_cyc, output logic busy1);
        nw = 0;
        done_cyc = 0;
        busy1 = 1'b0;
        @(posedge clk); #1 sb = 1'b1;
        @(posedge clk); #1 sb = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = busyb;
            if (ifb.y_wen) begin
                if (nw < 8) begin
                    b_wa[nw] = ifb.y_addr;
                    b_wd[nw] = ifb.y_data;
                end
                nw++;
            end
            if (doneb) begin
                done_cyc = c;
                break;
            end
            sb = (c == extra_start);
        end
        sb = 1'b0;
    endtask

    task automatic run_a(output int bad_addr, output int nw,
                         output int done_cyc);
        int off, e;
        bad_addr = 0;
        nw = 0;
        done_cyc = 0;
        @(posedge clk); #1 sa = 1'b1;
        @(posedge clk); #1 sa = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            off = (c - 1) % 7;
            e = (c - 1) / 7;
            if (e < 25 && off < 5) begin
                if (ifa.x_addr !== 32'((e / 5) * 5 + off) ||
                    ifa.w_addr !== 32'(off * 5 + e % 5))
                    bad_addr++;
            end
            if (ifa.y_wen) begin
                if (nw < 25) begin
                    ra[nw] = ifa.y_addr;
                    rd[nw] = ifa.y_data;
                    rc[nw] = c;
                end
                nw++;
            end
            if (donea) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic load_identity();
        xb[0] = 8'd1; xb[1] = 8'd2; xb[2] = 8'd3; xb[3] = 8'd4;
        wb[0] = 8'd1; wb[1] = 8'd0; wb[2] = 8'd0; wb[3] = 8'd1;
    endtask

    task automatic check_identity(input string tag, input int nw,
                                  input int dc);
        n_checks++;
        if (nw !== 4) begin
            n_fail++;
            $display("FAIL %s_writes: got %0d, expected 4", tag, nw);
        end
        n_checks++;
        if (dc !== 17) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d, expected 17", tag, dc);
        end
        for (int n = 0; n < 4; n++) begin
            n_checks++;
            if (b_wa[n] !== 32'(n) || b_wd[n] !== 8'(n + 1)) begin
                n_fail++;
                $display("FAIL %s_y%0d: got addr %0d data %0d, expected addr %0d data %0d",
                         tag, n, b_wa[n], $signed(b_wd[n]), n, n + 1);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({busya, donea, ifa.y_wen, busyb, doneb, ifb.y_wen} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {busya, donea, ifa.y_wen, busyb, doneb, ifb.y_wen});
        end
        n_checks++;
        if (ifa.x_addr !== 32'd0 || ifa.w_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rd_addr: got %0d/%0d, expected 0/0",
                     ifa.x_addr, ifa.w_addr);
        end
        n_checks++;
        if (ifa.y_addr !== 32'd0 || ifa.y_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_y: got %0d/%0d, expected 0/0",
                     ifa.y_addr, ifa.y_data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_identity();
        int nw, dc;
        logic b1;
        load_identity();
        run_b(0, nw, dc, b1);
        n_checks++;
        if (b1 !== 1'b1) begin
            n_fail++;
            $display("FAIL ident_busy_c1: got %b, expected 1", b1);
        end
        check_identity("ident", nw, dc);
        @(negedge clk);
        n_checks++;
        if (busyb !== 1'b0 || doneb !== 1'b0) begin
            n_fail++;
            $display("FAIL ident_after_done: got busy %b done %b, expected 0 0",
                     busyb, doneb);
        end
    endtask

    task automatic test_overflow();
        int nw, dc;
        logic b1;
        logic [7:0] exp;
`ifdef DFR_MM_SATURATE_EN
        exp = 8'd127;
`else
        exp = 8'h20;
`endif
        xb[0] = 8'd100; xb[1] = 8'd100; xb[2] = 8'd0; xb[3] = 8'd0;
        wb[0] = 8'd100; wb[1] = 8'd0; wb[2] = 8'd100; wb[3] = 8'd0;
        run_b(0, nw, dc, b1);
        n_checks++;
        if (nw !== 4 || b_wa[0] !== 32'd0 || b_wd[0] !== exp) begin
            n_fail++;
            $display("FAIL overflow: got n %0d addr %0d data %h, expected n 4 addr 0 data %h",
                     nw, b_wa[0], b_wd[0], exp);
        end
    endtask

    task automatic test_abort();
        int nw, dc, c0, bad;
        logic b1;
        load_identity();
        c0 = yb_cnt;
        @(posedge clk); #1 sb = 1'b1;
        @(posedge clk); #1 sb = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 cb = 1'b1;
        @(posedge clk); #1 cb = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busyb !== 1'b0 || ifb.y_wen !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_abort: got busy %b y_wen %b, expected 0 0",
                     busyb, ifb.y_wen);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (doneb || busyb || ifb.y_wen) bad++;
        end
        n_checks++;
        if (bad !== 0 || yb_cnt !== c0) begin
            n_fail++;
            $display("FAIL clr_quiet: got %0d active cycles %0d writes, expected 0 0",
                     bad, yb_cnt - c0);
        end
        run_b(0, nw, dc, b1);
        check_identity("clr_rerun", nw, dc);

        @(posedge clk); #1 sb = 1'b1;
        @(posedge clk); #1 sb = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifb.y_wen) break;
        end
        c0 = yb_cnt;
        n_checks++;
        if (ifb.y_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_reach_write: got y_wen %b, expected 1", ifb.y_wen);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (ifb.y_wen !== 1'b0 || busyb !== 1'b0 || ifb.y_data !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_async: got y_wen %b busy %b data %0d, expected 0 0 0",
                     ifb.y_wen, busyb, ifb.y_data);
        end
        @(posedge clk); #1 rst = 1'b1;
        n_checks++;
        if (yb_cnt !== c0) begin
            n_fail++;
            $display("FAIL rst_no_write: got %0d writes, expected 0", yb_cnt - c0);
        end
        run_b(0, nw, dc, b1);
        check_identity("rst_rerun", nw, dc);
    endtask

    task automatic test_start_handling();
        int nw, dc;
        logic b1;
        load_identity();
        run_b(5, nw, dc, b1);
        check_identity("start_busy", nw, dc);
        @(posedge clk); #1 begin sb = 1'b1; cb = 1'b1; end
        @(posedge clk); #1 begin sb = 1'b0; cb = 1'b0; end
        @(negedge clk);
        n_checks++;
        if (busyb !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clr: got busy %b, expected 0", busyb);
        end
    endtask

    task automatic test_back_to_back();
        int nw, dc;
        logic b1;
        load_identity();
        run_b(0, nw, dc, b1);
        run_b(0, nw, dc, b1);
        check_identity("b2b", nw, dc);
    endtask

    task automatic test_signed();
        int bad, nw, dc, nz;
        for (int n = 0; n < 25; n++) begin
            xa[n] = '0;
            wa[n] = '0;
        end
        xa[0] = -32'sd2; xa[1] = 32'sd3; xa[2] = 32'sd5;
        wa[0] = 32'sd4; wa[5] = -32'sd1; wa[10] = 32'sd2;
        run_a(bad, nw, dc);
        n_checks++;
        if (nw < 1 || ra[0] !== 32'd0 || rd[0] !== 32'hffffffff) begin
            n_fail++;
            $display("FAIL signed_y00: got addr %0d data %0d, expected addr 0 data -1",
                     ra[0], $signed(rd[0]));
        end
        nz = 0;
        for (int n = 1; n < 25; n++) if (rd[n] !== 32'd0) nz++;
        n_checks++;
        if (nz !== 0 || nw !== 25) begin
            n_fail++;
            $display("FAIL signed_rest: got %0d nonzero of %0d writes, expected 0 of 25",
                     nz, nw);
        end
    endtask

    task automatic test_random();
        int bad, nw, dc, v, ybad;
        longint s;
        for (int n = 0; n < 25; n++) begin
            v = int'($urandom_range(0, 2097151)) - 1048576;
            xa[n] = v;
            v = int'($urandom_range(0, 2097151)) - 1048576;
            wa[n] = v;
        end
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
                s = 0;
                for (int k = 0; k < 5; k++)
                    s += longint'($signed(xa[i*5+k])) * longint'($signed(wa[k*5+j]));
                exp_a[i*5+j] = fin32(s);
            end
        run_a(bad, nw, dc);
        n_checks++;
        if (nw !== 25) begin
            n_fail++;
            $display("FAIL rand_writes: got %0d, expected 25", nw);
        end
        n_checks++;
        if (dc !== 176 || rc[24] !== 175) begin
            n_fail++;
            $display("FAIL rand_timing: got last write %0d done %0d, expected 175 176",
                     rc[24], dc);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rand_rd_addr: got %0d bad cycles, expected 0", bad);
        end
        ybad = 0;
        for (int n = 0; n < 25; n++)
            if (ra[n] !== 32'(n) || rd[n] !== exp_a[n] || rc[n] !== 7 * n + 7)
                ybad++;
        n_checks++;
        if (ybad !== 0) begin
            n_fail++;
            $display("FAIL rand_y: got %0d wrong writes, expected 0", ybad);
        end
    endtask

    initial begin
        for (int n = 0; n < 25; n++) begin
            xa[n] = '0;
            wa[n] = '0;
        end
        test_reset();
        test_identity();
        test_overflow();
        test_abort();
        test_start_handling();
        test_back_to_back();
        test_signed();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dfr_matrix_multiply.md
Name: dfr_matrix_multiply

Overview:
- Output-layer engine of the DFR core.
- Computes Y = X * W, where X is the reservoir-history matrix (X_ROWS x X_COLS_Y_ROWS) and W is the trained output-weight matrix (X_COLS_Y_ROWS x Y_COLS).
- Operands are read from external single-port memories; each result element is written to an output memory.
- Driven by the core controller through start, clr and busy: the controller pulses start when the reservoir finishes and waits for busy to drop.

Parameters:
- ADDR_WIDTH, 32: width of all memory address ports.
- DATA_WIDTH, 32: width of operand and result words, signed two's complement.
- X_ROWS, 5: rows of X and rows of Y.
- Y_COLS, 5: columns of W and columns of Y.
- X_COLS_Y_ROWS, 5: inner dimension K (columns of X, rows of W); must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- clr  input  1  synchronous clear, driven by the controller's matrix_multiply_rst.
- start  input  1  single-cycle start request.
- busy  output  1  high while a multiply is in progress.
- done  output  1  single-cycle pulse when all of Y has been written.
- x_addr  output  ADDR_WIDTH  X memory read address, row-major: i*K+k.
- x_data  input  DATA_WIDTH  X read data, valid 1 cycle after x_addr.
- w_addr  output  ADDR_WIDTH  W memory read address, row-major: k*Y_COLS+j.
- w_data  input  DATA_WIDTH  W read data, valid 1 cycle after w_addr.
- y_addr  output  ADDR_WIDTH  Y write address, row-major: i*Y_COLS+j.
- y_data  output  DATA_WIDTH  Y write data.
- y_wen  output  1  Y write enable, one cycle per element.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; counters i, j, k = 0; accumulator = 0; read-valid pipe flag = 0.
  - busy, done, y_wen = 0; x_addr, w_addr, y_addr, y_data = 0.
  - Reset mid-operation aborts immediately; no partial write completes.
- States: IDLE, RUN, DRAIN, WRITE.
- IDLE:
  - start=1 at an edge: go to RUN, set i=j=k=0, clear accumulator.
  - busy is a registered signal and is high from the first RUN cycle, so it is already high in the cycle after the start pulse.
- RUN:
  - Issues one read pair per cycle for k = 0..K-1 on x_addr/w_addr.
  - The pipe flag goes high one cycle behind each issued read; while it is high, accumulator += signed(x_data) * signed(w_data).
  - After issuing k=K-1, go to DRAIN.
- DRAIN: one cycle that accumulates the final product.
- WRITE:
  - For one cycle: y_wen=1, y_addr = i*Y_COLS+j, y_data = result.
  - Accumulator and k are then cleared.
  - j increments; when j wraps from Y_COLS-1 to 0, i increments.
  - If i=X_ROWS-1 and j=Y_COLS-1: go to IDLE, pulse done on the next cycle, busy drops in that same cycle.
  - Otherwise: go back to RUN.
- Timing:
  - Cycles per element: K+2.
  - Total: X_ROWS*Y_COLS*(K+2) cycles from the first RUN cycle to the last write.
  - done pulses on the cycle after the last write.
- Arithmetic:
  - Product width is 2*DATA_WIDTH.
  - Accumulator width is 2*DATA_WIDTH + $clog2(K+1), with no internal overflow.
  - Result is the low DATA_WIDTH bits of the accumulator (wrap), unless the optional feature below is enabled.
- Simultaneous or out-of-sequence events:
  - start while busy: ignored.
  - clr=1: forces IDLE with all counters, accumulator and outputs cleared, and no done pulse. clr has priority over start in the same cycle.
  - start in the cycle after done: accepted normally.
- Memory outputs: x_addr and w_addr hold their last value outside RUN. y_wen is 0 outside WRITE.

Optional Feature:
- Macro: DFR_MM_SATURATE_EN.
- Defined: the result saturates to the signed DATA_WIDTH range.
  - Accumulator > 2^(DATA_WIDTH-1)-1 writes 2^(DATA_WIDTH-1)-1.
  - Accumulator < -2^(DATA_WIDTH-1) writes -2^(DATA_WIDTH-1).
- Undefined: low-bit truncation (wrap). Timing is identical either way.

Test Plan:
- Identity matrix, X_ROWS=Y_COLS=K=2: X=[[1,2],[3,4]], W=I -> writes Y=[[1,2],[3,4]] at addresses 0..3; done 17 cycles after start (first RUN cycle +16); busy high in the cycle after start.
- Signed values, K=3, 1x1: X=[-2,3,5], W=[4,-1,2] -> y_data=-1 at y_addr=0; exactly one y_wen pulse.
- Overflow, DATA_WIDTH=8, K=2, 1x1: X=[100,100], W=[100,100] (acc=20000):
  - Without macro: y_data=0x20 (low 8 bits of 20000).
  - With DFR_MM_SATURATE_EN: y_data=127.
- Abort: assert clr in the 3rd RUN cycle -> next cycle busy=0, y_wen=0, no done; a fresh start then gives correct results. Repeat using rst=0 mid-WRITE: y_wen drops asynchronously.
- Start handling: start pulse while busy -> ignored and result unchanged; start with clr in the same cycle -> stays IDLE.
- Default 5x5x5 with random signed operands -> 25 writes match the golden model; total 175 cycles; address sequences on x_addr/w_addr match the row-major formulas.
